// File: rtl/mem_access_pkg.sv
// dlx_mem_pkg: shared types and helpers
// for the DLX memory-access stage.
package dlx_mem_pkg;

  localparam logic [0:1] DS_BYTE = 2'b00;
  localparam logic [0:1] DS_HALF = 2'b01;
  localparam logic [0:1] DS_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  function automatic logic misaligned(
    input logic [0:1] lo,
    input logic [0:1] sz
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      sz == DS_HALF: r = lo[1];
      sz[0]:         r = (lo != 2'b00);
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [0:3] lane_be(
    input logic [0:1] lo,
    input logic [0:1] sz
  );
    logic [0:3] r;
    r = 4'b1111;
    unique case (1'b1)
      sz == DS_BYTE: r = 4'b1000 >> lo;
      sz == DS_HALF: r = lo[0] ? 4'b0011 : 4'b1100;
      default:       r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [0:31] lane_wdata(
    input logic [0:31] sd,
    input logic [0:1]  sz
  );
    logic [0:31] r;
    r = sd;
    unique case (1'b1)
      sz == DS_BYTE: r = {4{sd[24:31]}};
      sz == DS_HALF: r = {2{sd[16:31]}};
      default:       r = sd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory req/ack port
// between the mem stage and data memory.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [0:31] dmem_addr;
  logic [0:3]  dmem_be;
  logic [0:31] dmem_wdata;
  logic [0:31] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access_load_align.sv
// load_align: picks the addressed lane of
// big-endian read data and extends it.
module load_align
  import dlx_mem_pkg::*;
(
  input  logic [0:31] rdata,
  input  logic [0:1]  offset,
  input  logic [0:1]  size,
  input  logic        sign,
  output logic [0:31] data
);

  logic [0:7]  b;
  logic [0:15] h;

  // lane select then sign/zero extend
  always_comb begin
    b = rdata[0:7];
    unique case (offset)
      2'b00: b = rdata[0:7];
      2'b01: b = rdata[8:15];
      2'b10: b = rdata[16:23];
      2'b11: b = rdata[24:31];
    endcase
    h = offset[0] ? rdata[16:31] : rdata[0:15];
    data = rdata;
    unique case (1'b1)
      size == DS_BYTE: data = {{24{sign & b[0]}}, b};
      size == DS_HALF: data = {{16{sign & h[0]}}, h};
      default:         data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: DLX memory stage, drives the
// dmem req/ack port and the WB bundle.
module mem_access
  import dlx_mem_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [0:31] aluResult_in,
  input  logic [0:31] storeData_in,
  input  logic [0:31] nextPC_in,
  input  logic [0:4]  destReg_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemWrite_in,
  input  logic        loadSign_in,
  input  logic        PCtoReg_in,
  input  logic [0:1]  DSize_in,
  output logic        stall_out,
  mem_access_if.master dmem,
  output logic        valid_out,
  output logic [0:31] wbData_out,
  output logic [0:4]  destReg_out,
  output logic        RegWrite_out,
  output logic        err_out
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:31]   addr_q, addr_d;
  logic [0:3]    be_q, be_d;
  logic [0:31]   wdata_q, wdata_d;
  logic [0:1]    off_q, off_d;
  logic [0:1]    size_q, size_d;
  logic          sign_q, sign_d;
  logic [0:4]    dest_q, dest_d;
  logic          rw_q, rw_d;
  logic          we_q, we_d;
  logic          valid_q, valid_d;
  logic [0:31]   wb_q, wb_d;
  logic [0:4]    wbdest_q, wbdest_d;
  logic          wbrw_q, wbrw_d;
  logic          err_q, err_d;

  logic          mem_op;
  logic          mis;
  logic          in_wait;
  logic          timeout;
  logic [0:31]   ld_data;

  assign mem_op  = MemToReg_in | MemWrite_in;
  assign mis     = misaligned(aluResult_in[30:31], DSize_in);
  assign in_wait = (state_q == WAIT);
  assign timeout = in_wait & ~dmem.dmem_ack
                 & (cnt_q == CW'(WAIT_LIMIT - 1));

  load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .offset (off_q),
    .size   (size_q),
    .sign   (sign_q),
    .data   (ld_data)
  );

  // next-state and writeback bundle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    size_d   = size_q;
    sign_d   = sign_q;
    dest_d   = dest_q;
    rw_d     = rw_q;
    we_d     = we_q;
    valid_d  = 1'b0;
    wb_d     = wb_q;
    wbdest_d = wbdest_q;
    wbrw_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_in && !mem_op) begin
          valid_d  = 1'b1;
          wbrw_d   = RegWrite_in;
          wbdest_d = destReg_in;
          wb_d     = PCtoReg_in ? nextPC_in : aluResult_in;
        end else if (valid_in && mis) begin
          valid_d  = 1'b1;
          err_d    = 1'b1;
          wbdest_d = destReg_in;
          wb_d     = '0;
        end else if (valid_in) begin
          state_d = WAIT;
          cnt_d   = '0;
          addr_d  = {aluResult_in[0:29], 2'b00};
          be_d    = lane_be(aluResult_in[30:31], DSize_in);
          wdata_d = lane_wdata(storeData_in, DSize_in);
          off_d   = aluResult_in[30:31];
          size_d  = DSize_in;
          sign_d  = loadSign_in;
          dest_d  = destReg_in;
          rw_d    = RegWrite_in;
          we_d    = MemWrite_in;
        end
      end
      WAIT: begin
        if (dmem.dmem_ack) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          wbdest_d = dest_q;
          wbrw_d   = rw_q & ~we_q;
          wb_d     = we_q ? '0 : ld_data;
        end else if (timeout) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          err_d    = 1'b1;
          wbdest_d = dest_q;
          wb_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // state and bundle registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      dest_q   <= '0;
      rw_q     <= 1'b0;
      we_q     <= 1'b0;
      valid_q  <= 1'b0;
      wb_q     <= '0;
      wbdest_q <= '0;
      wbrw_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      dest_q   <= dest_d;
      rw_q     <= rw_d;
      we_q     <= we_d;
      valid_q  <= valid_d;
      wb_q     <= wb_d;
      wbdest_q <= wbdest_d;
      wbrw_q   <= wbrw_d;
      err_q    <= err_d;
    end
  end

  assign dmem.dmem_req   = in_wait;
  assign dmem.dmem_we    = in_wait & we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign stall_out = (~in_wait & valid_in & mem_op & ~mis)
                   | (in_wait & ~dmem.dmem_ack & ~timeout);

  assign valid_out    = valid_q;
  assign wbData_out   = wb_q;
  assign destReg_out  = wbdest_q;
  assign RegWrite_out = wbrw_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for the
// DLX memory-access stage.
module tb_mem_access;
  import dlx_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [0:31] aluResult_in = '0;
  logic [0:31] storeData_in = '0;
  logic [0:31] nextPC_in = '0;
  logic [0:4]  destReg_in = '0;
  logic        RegWrite_in = 1'b0;
  logic        MemToReg_in = 1'b0;
  logic        MemWrite_in = 1'b0;
  logic        loadSign_in = 1'b0;
  logic        PCtoReg_in = 1'b0;
  logic [0:1]  DSize_in = '0;
  logic        stall_out;
  logic        valid_out;
  logic [0:31] wbData_out;
  logic [0:4]  destReg_out;
  logic        RegWrite_out;
  logic        err_out;

  mem_access_if dif ();

  mem_access #(.WAIT_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .aluResult_in (aluResult_in),
    .storeData_in (storeData_in),
    .nextPC_in    (nextPC_in),
    .destReg_in   (destReg_in),
    .RegWrite_in  (RegWrite_in),
    .MemToReg_in  (MemToReg_in),
    .MemWrite_in  (MemWrite_in),
    .loadSign_in  (loadSign_in),
    .PCtoReg_in   (PCtoReg_in),
    .DSize_in     (DSize_in),
    .stall_out    (stall_out),
    .dmem         (dif.master),
    .valid_out    (valid_out),
    .wbData_out   (wbData_out),
    .destReg_out  (destReg_out),
    .RegWrite_out (RegWrite_out),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  dest;
    logic        rw;
    logic        err;
    logic        cwb;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] wb,
                      input logic [4:0] dest,
                      input logic rw, input logic err,
                      input logic cwb);
    exp_t x;
    x.wb = wb; x.dest = dest; x.rw = rw;
    x.err = err; x.cwb = cwb;
    sb.push_back(x);
  endtask

  // pop expected writeback on every valid_out
  always @(negedge clk) begin
    if (valid_out) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.cwb) chk("wb_data", wbData_out, e.wb);
        chk("wb_dest", 32'(destReg_out), 32'(e.dest));
        chk("wb_rw", 32'(RegWrite_out), 32'(e.rw));
        chk("wb_err", 32'(err_out), 32'(e.err));
      end
    end
  end

  task automatic drive(input logic [31:0] alu,
                       input logic [31:0] sd,
                       input logic [31:0] npc,
                       input logic [4:0] dest,
                       input logic rw, input logic m2r,
                       input logic mw, input logic sgn,
                       input logic pc2r,
                       input logic [1:0] ds);
    @(posedge clk); #1;
    valid_in = 1'b1;
    aluResult_in = alu;
    storeData_in = sd;
    nextPC_in = npc;
    destReg_in = dest;
    RegWrite_in = rw;
    MemToReg_in = m2r;
    MemWrite_in = mw;
    loadSign_in = sgn;
    PCtoReg_in = pc2r;
    DSize_in = ds;
  endtask

  task automatic release_in();
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic mem_xact(input logic [31:0] addr,
                          input logic [3:0] be,
                          input logic [31:0] wd,
                          input logic cwd,
                          input logic we,
                          input int dly,
                          input logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!dif.dmem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req", 32'(dif.dmem_req), 32'd1);
    chk("addr", dif.dmem_addr, addr);
    chk("be", 32'(dif.dmem_be), 32'(be));
    if (cwd) chk("wdata", dif.dmem_wdata, wd);
    chk("we", 32'(dif.dmem_we), 32'(we));
    chk("wait_stall", 32'(stall_out), 32'd1);
    repeat (dly) @(posedge clk);
    #1;
    dif.dmem_ack = 1'b1;
    dif.dmem_rdata = rd;
    #2 chk("ack_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    dif.dmem_ack = 1'b0;
    dif.dmem_rdata = '0;
    @(negedge clk);
    chk("ack_lat", 32'(valid_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqc, stc, n;
    dif.dmem_ack = 1'b0;
    dif.dmem_rdata = '0;

    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_req", 32'(dif.dmem_req), 0);
    chk("rst_we", 32'(dif.dmem_we), 0);
    chk("rst_addr", dif.dmem_addr, 0);
    chk("rst_be", 32'(dif.dmem_be), 0);
    chk("rst_wdata", dif.dmem_wdata, 0);
    chk("rst_wb", wbData_out, 0);
    chk("rst_dest", 32'(destReg_out), 0);
    chk("rst_rw", 32'(RegWrite_out), 0);
    chk("rst_err", 32'(err_out), 0);
    @(posedge clk); #1 reset = 1'b1;

    // back-to-back ALU ops, one with link value
    drive(32'h1234, 0, 0, 5, 1, 0, 0, 0, 0, DS_WORD);
    push(32'h1234, 5, 1, 0, 1);
    @(negedge clk) chk("alu_stall", 32'(stall_out), 0);
    drive(32'hDEAD, 0, 32'h4444, 9, 1, 0, 0, 0, 1, DS_WORD);
    push(32'h4444, 9, 1, 0, 1);
    @(negedge clk) chk("b2b_valid1", 32'(valid_out), 1);
    chk("link_stall", 32'(stall_out), 0);
    drive(32'h77, 0, 0, 3, 0, 0, 0, 0, 0, DS_WORD);
    push(32'h77, 3, 0, 0, 1);
    @(negedge clk) chk("b2b_valid2", 32'(valid_out), 1);
    release_in();

    // signed byte load, ack after 2 wait cycles
    drive(32'h103, 0, 0, 7, 1, 1, 0, 1, 0, DS_BYTE);
    push(32'hFFFF_FFF0, 7, 1, 0, 1);
    @(negedge clk) chk("ldb_stall", 32'(stall_out), 1);
    release_in();
    mem_xact(32'h100, 4'b0001, 0, 0, 0, 2, 32'h1122_33F0);

    // half store
    drive(32'h202, 32'hABCD, 0, 4, 1, 0, 1, 0, 0, DS_HALF);
    push(0, 4, 0, 0, 0);
    release_in();
    mem_xact(32'h200, 4'b0011, 32'hABCD_ABCD, 1, 1, 1, 0);

    // byte store
    drive(32'h401, 32'h5A, 0, 2, 0, 0, 1, 0, 0, DS_BYTE);
    push(0, 2, 0, 0, 0);
    release_in();
    mem_xact(32'h400, 4'b0100, 32'h5A5A_5A5A, 1, 1, 0, 0);

    // unsigned half load, immediate ack
    drive(32'h100, 0, 0, 6, 1, 1, 0, 0, 0, DS_HALF);
    push(32'h0000_8001, 6, 1, 0, 1);
    release_in();
    mem_xact(32'h100, 4'b1100, 0, 0, 0, 0, 32'h8001_7777);

    // signed half load, low lane
    drive(32'h10A, 0, 0, 12, 1, 1, 0, 1, 0, DS_HALF);
    push(32'hFFFF_8001, 12, 1, 0, 1);
    release_in();
    mem_xact(32'h108, 4'b0011, 0, 0, 0, 1, 32'h1234_8001);

    // signed word-size load returns word as-is
    drive(32'h20C, 0, 0, 13, 1, 1, 0, 1, 0, 2'b11);
    push(32'h8765_4321, 13, 1, 0, 1);
    release_in();
    mem_xact(32'h20C, 4'b1111, 0, 0, 0, 0, 32'h8765_4321);

    // misaligned word load
    drive(32'h106, 0, 0, 8, 1, 1, 0, 0, 0, DS_WORD);
    push(0, 8, 0, 1, 0);
    @(negedge clk);
    chk("mis_stall", 32'(stall_out), 0);
    chk("mis_req0", 32'(dif.dmem_req), 0);
    release_in();
    @(negedge clk) chk("mis_req1", 32'(dif.dmem_req), 0);

    // misaligned half store
    drive(32'h101, 32'h55, 0, 14, 1, 0, 1, 0, 0, DS_HALF);
    push(0, 14, 0, 1, 0);
    release_in();
    @(negedge clk) chk("mish_req", 32'(dif.dmem_req), 0);

    // timeout with no ack
    drive(32'h300, 0, 0, 10, 1, 1, 0, 0, 0, DS_WORD);
    push(0, 10, 0, 1, 0);
    release_in();
    reqc = 0; stc = 0; n = 0;
    @(negedge clk);
    while (dif.dmem_req && n < 20) begin
      reqc++;
      if (stall_out) stc++;
      @(negedge clk);
      n++;
    end
    chk("to_req_cycles", 32'(reqc), 4);
    chk("to_stall_cycles", 32'(stc), 3);
    chk("to_stall_rel", 32'(stall_out), 0);
    chk("to_valid", 32'(valid_out), 1);

    // reset while waiting, late ack ignored
    drive(32'h500, 0, 0, 11, 1, 1, 0, 0, 0, DS_WORD);
    release_in();
    @(negedge clk) chk("rw_req_before", 32'(dif.dmem_req), 1);
    #1 reset = 1'b0;
    #1 chk("rw_req_async", 32'(dif.dmem_req), 0);
    chk("rw_valid", 32'(valid_out), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    dif.dmem_ack = 1'b1;
    dif.dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dif.dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_req", 32'(dif.dmem_req), 0);
      chk("late_valid", 32'(valid_out), 0);
    end

    // ALU op after reset still works
    drive(32'h9999, 0, 0, 1, 1, 0, 0, 0, 0, DS_WORD);
    push(32'h9999, 1, 1, 0, 1);
    release_in();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
